mem_cmd_sequencer: RTL and testbench

- Drains the 290-bit memory command FIFO (first-word-fall-through, read side) and executes each command as an 8-beat, 32-bit burst on the memory bus.
- Write commands stream the 256-bit line out beat by beat.
- Read commands collect 8 beats into a 256-bit line and push it into the 256-bit response FIFO.
- Sits between the command FIFO read port and the memory controller, in the memory clock domain.

---
 rtl/mem_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_sequencer.sv
// Memory command sequencer: pops commands from the FWFT command FIFO and runs each one
// as an 8-beat burst, streaming write lines out or assembling read lines for the response FIFO.
module mem_cmd_sequencer #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned BUS_W = 32
) (
  input  logic                     clk,
  input  logic                     i_nRst,
  input  logic [BEATS*BUS_W+33:0]  i_cmd,
  input  logic                     i_cmdEmpty,
  output logic                     o_cmdRdreq,
  output logic                     o_busReq,
  output logic                     o_busWrite,
  output logic [31:0]              o_busAddr,
  input  logic                     i_busAck,
  output logic                     o_busWValid,
  output logic [BUS_W-1:0]         o_busWData,
  input  logic                     i_busWReady,
  input  logic                     i_busRValid,
  input  logic [BUS_W-1:0]         i_busRData,
  output logic [BEATS*BUS_W-1:0]   o_rspData,
  output logic                     o_rspWrreq,
  input  logic                     i_rspFull,
  output logic                     o_busy,
  output logic [7:0]               o_dropCount
);

  localparam int unsigned LINE_W = BEATS * BUS_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LINE_B = LINE_W / 8;
  localparam logic [1:0]  OP_WR  = 2'b01;
  localparam logic [1:0]  OP_RD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WBEAT,
    ST_RBEAT,
    ST_PUSH
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   beat_q,      beat_d;
  logic [LINE_W-1:0]  line_q,      line_d;
  logic [7:0]         drop_q,      drop_d;
  logic               cmd_rdreq_q, cmd_rdreq_d;
  logic               bus_req_q,   bus_req_d;
  logic               bus_write_q, bus_write_d;
  logic [31:0]        bus_addr_q,  bus_addr_d;
  logic               wvalid_q,    wvalid_d;
  logic [LINE_W-1:0]  rsp_data_q,  rsp_data_d;
  logic               rsp_wrreq_q, rsp_wrreq_d;
  logic               busy_q,      busy_d;

  logic [1:0]         cmd_op;
  logic [31:0]        cmd_addr;
  logic               last_beat;

  assign cmd_op    = i_cmd[LINE_W+33:LINE_W+32];
  assign cmd_addr  = i_cmd[LINE_W+31:LINE_W];
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!i_nRst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      drop_q      <= '0;
      cmd_rdreq_q <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      wvalid_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_wrreq_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      drop_q      <= drop_d;
      cmd_rdreq_q <= cmd_rdreq_d;
      bus_req_q   <= bus_req_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      wvalid_q    <= wvalid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wrreq_q <= rsp_wrreq_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    drop_d      = drop_q;
    cmd_rdreq_d = 1'b0;
    bus_req_d   = bus_req_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    wvalid_d    = wvalid_q;
    rsp_data_d  = rsp_data_q;
    rsp_wrreq_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The pop strobe is registered, so the head is still the old word while it is high
        if (!i_cmdEmpty && !cmd_rdreq_q) begin
          cmd_rdreq_d = 1'b1;
          if (cmd_op == OP_WR || cmd_op == OP_RD) begin
            line_d      = i_cmd[LINE_W-1:0];
            bus_addr_d  = cmd_addr & ~32'(LINE_B - 1);
            bus_write_d = (cmd_op == OP_WR);
            bus_req_d   = 1'b1;
            state_d     = ST_REQ;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_REQ: begin
        if (i_busAck) begin
          bus_req_d = 1'b0;
          beat_d    = '0;
          if (bus_write_q) begin
            wvalid_d = 1'b1;
            state_d  = ST_WBEAT;
          end else begin
            state_d  = ST_RBEAT;
          end
        end
      end
      ST_WBEAT: begin
        if (i_busWReady) begin
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) begin
            wvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_RBEAT: begin
        if (i_busRValid) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == CNT_W'(k)) rsp_data_d[k*BUS_W +: BUS_W] = i_busRData;
          end
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!i_rspFull) begin
          rsp_wrreq_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Write beat data selected from the latched line by the beat counter
  always_comb begin
    o_busWData = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_q == CNT_W'(k)) o_busWData = line_q[k*BUS_W +: BUS_W];
    end
  end

  assign o_cmdRdreq  = cmd_rdreq_q;
  assign o_busReq    = bus_req_q;
  assign o_busWrite  = bus_write_q;
  assign o_busAddr   = bus_addr_q;
  assign o_busWValid = wvalid_q;
  assign o_rspData   = rsp_data_q;
  assign o_rspWrreq  = rsp_wrreq_q;
  assign o_busy      = busy_q;
  assign o_dropCount = drop_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Directed bench for mem_cmd_sequencer: FWFT command FIFO model, bus responder and
// hand-computed expected beats, lines and counters.
module tb_mem_cmd_sequencer;

  logic         clk;
  logic         i_nRst;
  logic [289:0] i_cmd;
  logic         i_cmdEmpty;
  logic         o_cmdRdreq;
  logic         o_busReq;
  logic         o_busWrite;
  logic [31:0]  o_busAddr;
  logic         i_busAck;
  logic         o_busWValid;
  logic [31:0]  o_busWData;
  logic         i_busWReady;
  logic         i_busRValid;
  logic [31:0]  i_busRData;
  logic [255:0] o_rspData;
  logic         o_rspWrreq;
  logic         i_rspFull;
  logic         o_busy;
  logic [7:0]   o_dropCount;

  mem_cmd_sequencer #(.BEATS(8), .BUS_W(32)) dut (
    .clk         (clk),
    .i_nRst      (i_nRst),
    .i_cmd       (i_cmd),
    .i_cmdEmpty  (i_cmdEmpty),
    .o_cmdRdreq  (o_cmdRdreq),
    .o_busReq    (o_busReq),
    .o_busWrite  (o_busWrite),
    .o_busAddr   (o_busAddr),
    .i_busAck    (i_busAck),
    .o_busWValid (o_busWValid),
    .o_busWData  (o_busWData),
    .i_busWReady (i_busWReady),
    .i_busRValid (i_busRValid),
    .i_busRData  (i_busRData),
    .o_rspData   (o_rspData),
    .o_rspWrreq  (o_rspWrreq),
    .i_rspFull   (i_rspFull),
    .o_busy      (o_busy),
    .o_dropCount (o_dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [289:0] cmd_q[$];
  logic [31:0]  rd_q[$];
  logic [31:0]  wbeats[$];
  int           n_cmp, n_err;
  int           n_pops, bursts, rsp_cnt, req_cyc, req_max, stab_err, wv_cyc, ack_dly;
  logic [255:0] rsp_last;
  bit           armed, gaps, spur, ph, prev_req, prev_wr;
  logic [31:0]  prev_addr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [289:0] mk_cmd(input logic [1:0] op, input logic [31:0] addr,
                                          input logic [255:0] line);
    return {op, addr, line};
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] stride);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + stride * 32'(k);
    return l;
  endfunction

  task automatic reset_counters();
    n_pops = 0; bursts = 0; rsp_cnt = 0; req_max = 0; stab_err = 0; wv_cyc = 0;
    wbeats.delete();
  endtask

  task automatic push_cmd(input logic [289:0] c);
    cmd_q.push_back(c);
    i_cmdEmpty = 1'b0;
    i_cmd      = cmd_q[0];
  endtask

  // One clock: record handshakes before the edge, then update FIFO/bus models after it
  task automatic step();
    logic pop, hs_w, hs_r, ack_rd;
    pop    = o_cmdRdreq && i_nRst;
    hs_w   = o_busWValid && i_busWReady && i_nRst;
    hs_r   = i_busRValid && armed && i_nRst;
    ack_rd = o_busReq && i_busAck && !o_busWrite && i_nRst;
    if (hs_w) wbeats.push_back(o_busWData);
    if (o_busWValid && i_nRst) wv_cyc++;
    if (o_rspWrreq && i_nRst) begin rsp_cnt++; rsp_last = o_rspData; end
    @(posedge clk);
    #1;
    if (pop && cmd_q.size() > 0) begin void'(cmd_q.pop_front()); n_pops++; end
    if (hs_r && rd_q.size() > 0) begin
      void'(rd_q.pop_front());
      if (rd_q.size() == 0) armed = 1'b0;
    end
    if (ack_rd) armed = 1'b1;
    if (o_busReq) begin
      if (prev_req) begin
        if (o_busAddr !== prev_addr || o_busWrite !== prev_wr) stab_err++;
      end else begin
        bursts++;
      end
      req_cyc++;
      if (req_cyc > req_max) req_max = req_cyc;
    end else begin
      req_cyc = 0;
    end
    prev_req  = o_busReq;
    prev_addr = o_busAddr;
    prev_wr   = o_busWrite;
    i_cmdEmpty  = (cmd_q.size() == 0);
    i_cmd       = (cmd_q.size() > 0) ? cmd_q[0] : '0;
    i_busAck    = o_busReq && (req_cyc > ack_dly);
    ph          = ~ph;
    i_busRValid = armed ? ((ph || !gaps) && rd_q.size() > 0) : spur;
    i_busRData  = (armed && rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (cmd_q.size() == 0 && !o_busy && !o_cmdRdreq && !o_rspWrreq) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_done"}, 256'(done), 256'(1));
  endtask

  task automatic check_beats(input string tag, input logic [255:0] line);
    chk({tag, "_nbeats"}, 256'(wbeats.size()), 256'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < wbeats.size()) chk($sformatf("%s_beat%0d", tag, k), 256'(wbeats[k]), 256'(line[k*32 +: 32]));
    end
  endtask

  task automatic load_rd(input logic [31:0] base);
    rd_q.delete();
    for (int k = 0; k < 8; k++) rd_q.push_back(base + 32'(k));
  endtask

  logic [255:0] line1, line3, line4, line5a, line5b, line6, exp_rd;
  bit           reached;

  initial begin
    i_nRst = 1'b0; i_cmd = '0; i_cmdEmpty = 1'b1; i_busAck = 1'b0; i_busWReady = 1'b0;
    i_busRValid = 1'b0; i_busRData = '0; i_rspFull = 1'b0;
    n_cmp = 0; n_err = 0; armed = 0; gaps = 0; spur = 0; ph = 0; prev_req = 0; prev_wr = 0;
    prev_addr = '0; req_cyc = 0; ack_dly = 0; rsp_last = '0;
    reset_counters();

    repeat (3) step();
    chk("rst_busy",   256'(o_busy),      256'(0));
    chk("rst_req",    256'(o_busReq),    256'(0));
    chk("rst_wvalid", 256'(o_busWValid), 256'(0));
    chk("rst_rdreq",  256'(o_cmdRdreq),  256'(0));
    chk("rst_drop",   256'(o_dropCount), 256'(0));
    chk("rst_rsp",    o_rspData,         256'(0));
    chk("rst_wdata",  256'(o_busWData),  256'(0));
    chk("rst_addr",   256'(o_busAddr),   256'(0));
    i_nRst = 1'b1;
    step();

    // 1: write, immediate ack, no back-pressure
    reset_counters();
    line1 = mk_line(32'h1111_1111, 32'h1111_1111);
    i_busWReady = 1'b1;
    push_cmd(mk_cmd(2'b01, 32'h0000_1234, line1));
    step();
    chk("t1_req",   256'(o_busReq),   256'(1));
    chk("t1_rdreq", 256'(o_cmdRdreq), 256'(1));
    chk("t1_addr",  256'(o_busAddr),  256'(32'h0000_1220));
    chk("t1_write", 256'(o_busWrite), 256'(1));
    drain("t1", 100);
    check_beats("t1", line1);
    chk("t1_wvcyc", 256'(wv_cyc), 256'(8));
    chk("t1_pops",  256'(n_pops), 256'(1));
    chk("t1_busy",  256'(o_busy), 256'(0));

    // 2: read with beats on alternating cycles
    reset_counters();
    gaps = 1'b1;
    load_rd(32'hA0);
    exp_rd = mk_line(32'hA0, 32'h1);
    push_cmd(mk_cmd(2'b10, 32'h0000_0040, '0));
    drain("t2", 100);
    chk("t2_addr",   256'(o_busAddr), 256'(32'h40));
    chk("t2_pushes", 256'(rsp_cnt),   256'(1));
    chk("t2_line",   rsp_last,        exp_rd);
    chk("t2_pops",   256'(n_pops),    256'(1));
    chk("t2_bursts", 256'(bursts),    256'(1));

    // 3: read with the response FIFO full for 5 cycles, then a queued write
    reset_counters();
    i_rspFull = 1'b1;
    load_rd(32'hB0);
    exp_rd = mk_line(32'hB0, 32'h1);
    line3  = mk_line(32'h3000_0000, 32'h0000_0101);
    push_cmd(mk_cmd(2'b10, 32'h0000_0080, '0));
    push_cmd(mk_cmd(2'b01, 32'h0000_0500, line3));
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_q.size() == 0) begin reached = 1'b1; break; end
      step();
    end
    chk("t3_beats_done", 256'(reached), 256'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_hold%0d", i), 256'(o_rspWrreq), 256'(0));
      chk($sformatf("t3_data%0d", i), o_rspData, exp_rd);
    end
    chk("t3_pops_wait", 256'(n_pops), 256'(1));
    i_rspFull = 1'b0;
    step();
    chk("t3_push",      256'(o_rspWrreq), 256'(1));
    chk("t3_push_data", o_rspData,        exp_rd);
    drain("t3", 100);
    chk("t3_pushes", 256'(rsp_cnt), 256'(1));
    chk("t3_pops",   256'(n_pops),  256'(2));
    chk("t3_bursts", 256'(bursts),  256'(2));
    check_beats("t3", line3);

    // 4: two illegal ops dropped, then a write
    reset_counters();
    line4 = mk_line(32'h4444_0000, 32'h0000_0011);
    push_cmd(mk_cmd(2'b00, 32'h0000_0600, '1));
    push_cmd(mk_cmd(2'b11, 32'h0000_0640, '1));
    push_cmd(mk_cmd(2'b01, 32'h0000_0700, line4));
    drain("t4", 100);
    chk("t4_drop",   256'(o_dropCount), 256'(2));
    chk("t4_pops",   256'(n_pops),      256'(3));
    chk("t4_bursts", 256'(bursts),      256'(1));
    chk("t4_addr",   256'(o_busAddr),   256'(32'h0700));
    check_beats("t4", line4);

    // 5: reset during write beat 3, then the next head runs cleanly
    reset_counters();
    line5a = mk_line(32'hA5A5_0000, 32'h1);
    line5b = mk_line(32'h5A5A_0000, 32'h10);
    push_cmd(mk_cmd(2'b01, 32'h0000_0300, line5a));
    push_cmd(mk_cmd(2'b01, 32'h0000_0400, line5b));
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wbeats.size() == 3) begin reached = 1'b1; break; end
      step();
    end
    chk("t5_beat3", 256'(reached), 256'(1));
    i_nRst = 1'b0;
    step();
    chk("t5_req",    256'(o_busReq),    256'(0));
    chk("t5_wvalid", 256'(o_busWValid), 256'(0));
    chk("t5_rdreq",  256'(o_cmdRdreq),  256'(0));
    chk("t5_wrreq",  256'(o_rspWrreq),  256'(0));
    chk("t5_busy",   256'(o_busy),      256'(0));
    chk("t5_drop",   256'(o_dropCount), 256'(0));
    chk("t5_wdata",  256'(o_busWData),  256'(0));
    i_nRst = 1'b1;
    reset_counters();
    drain("t5", 100);
    check_beats("t5", line5b);
    chk("t5_pops",   256'(n_pops),    256'(1));
    chk("t5_bursts", 256'(bursts),    256'(1));
    chk("t5_addr",   256'(o_busAddr), 256'(32'h0400));

    // 6: spurious RValid in IDLE/WBEAT/REQ, ack held off for 10 cycles
    reset_counters();
    spur = 1'b1;
    repeat (4) step();
    ack_dly = 10;
    line6 = mk_line(32'h6060_0000, 32'h0000_0303);
    push_cmd(mk_cmd(2'b01, 32'h0000_2FFF, line6));
    drain("t6w", 150);
    check_beats("t6w", line6);
    chk("t6w_reqlen", 256'(req_max),   256'(11));
    chk("t6w_stable", 256'(stab_err),  256'(0));
    chk("t6w_addr",   256'(o_busAddr), 256'(32'h2FE0));
    reset_counters();
    load_rd(32'hC0);
    exp_rd = mk_line(32'hC0, 32'h1);
    push_cmd(mk_cmd(2'b10, 32'h0001_0055, '0));
    drain("t6r", 150);
    chk("t6r_pushes", 256'(rsp_cnt),   256'(1));
    chk("t6r_line",   rsp_last,        exp_rd);
    chk("t6r_reqlen", 256'(req_max),   256'(11));
    chk("t6r_stable", 256'(stab_err),  256'(0));
    chk("t6r_addr",   256'(o_busAddr), 256'(32'h0001_0040));
    spur = 1'b0;
    ack_dly = 0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
